// File: rtl/dispatch_bundler_if.sv
// Rename-to-issue-window bus of the dispatch bundler: rename offer, wake broadcasts,
// window back-pressure and the packed 4-slot bundle. master = bundler side.
interface dispatch_bundler_if #(parameter int PHY_W = 6);
  logic               flush;
  logic               In_Valid;
  logic               In_Ready;
  logic [3:0]         In_Function;
  logic [4:0]         In_Operation;
  logic [31:0]        In_imm;
  logic [31:0]        In_PC;
  logic [PHY_W-1:0]   In_Phydst;
  logic [PHY_W-1:0]   In_Src1;
  logic [PHY_W-1:0]   In_Src2;
  logic               In_Src1_Wake;
  logic               In_Src2_Wake;
  logic [4:0]         In_Rdst;

  logic               ALU0_Commit;
  logic               ALU1_Commit;
  logic               BU_Commit;
  logic               DU_Commit;
  logic [PHY_W-1:0]   ALU0_Phydst;
  logic [PHY_W-1:0]   ALU1_Phydst;
  logic [PHY_W-1:0]   BU_Phydst;
  logic [PHY_W-1:0]   DU_Phydst;

  logic               Issue_window_full;

  logic [3:0]         Inst_Valid;
  logic [15:0]        Inst_Function;
  logic [19:0]        Inst_Operation;
  logic [127:0]       Inst_imm;
  logic [127:0]       Inst_PC;
  logic [4*PHY_W-1:0] Inst_Phydst;
  logic [4*PHY_W-1:0] Inst_Src1;
  logic [4*PHY_W-1:0] Inst_Src2;
  logic [3:0]         Inst_Src1_Wake;
  logic [3:0]         Inst_Src2_Wake;
  logic [19:0]        Inst_Rdst;
  logic [2:0]         Bundle_Count;

  modport master (
    input  flush, In_Valid, In_Function, In_Operation, In_imm, In_PC,
           In_Phydst, In_Src1, In_Src2, In_Src1_Wake, In_Src2_Wake, In_Rdst,
           ALU0_Commit, ALU1_Commit, BU_Commit, DU_Commit,
           ALU0_Phydst, ALU1_Phydst, BU_Phydst, DU_Phydst, Issue_window_full,
    output In_Ready, Inst_Valid, Inst_Function, Inst_Operation, Inst_imm, Inst_PC,
           Inst_Phydst, Inst_Src1, Inst_Src2, Inst_Src1_Wake, Inst_Src2_Wake,
           Inst_Rdst, Bundle_Count
  );

  modport slave (
    output flush, In_Valid, In_Function, In_Operation, In_imm, In_PC,
           In_Phydst, In_Src1, In_Src2, In_Src1_Wake, In_Src2_Wake, In_Rdst,
           ALU0_Commit, ALU1_Commit, BU_Commit, DU_Commit,
           ALU0_Phydst, ALU1_Phydst, BU_Phydst, DU_Phydst, Issue_window_full,
    input  In_Ready, Inst_Valid, Inst_Function, Inst_Operation, Inst_imm, Inst_PC,
           Inst_Phydst, Inst_Src1, Inst_Src2, Inst_Src1_Wake, Inst_Src2_Wake,
           Inst_Rdst, Bundle_Count
  );
endinterface

// File: rtl/dispatch_bundler.sv
// Packs renamed instructions into 4-slot bundles for the issue window write port.
// Optional wake-broadcast snooping of parked source-ready bits: DISPATCH_WAKE_SNOOP_EN.
module dispatch_bundler #(
  parameter int TIMEOUT = 4,
  parameter int PHY_W   = 6
) (
  input logic               clk,
  input logic               rst,
  dispatch_bundler_if.master bus
);

  typedef struct packed {
    logic [3:0]       func;
    logic [4:0]       op;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [PHY_W-1:0] phydst;
    logic [PHY_W-1:0] src1;
    logic [PHY_W-1:0] src2;
    logic             src1_wake;
    logic             src2_wake;
    logic [4:0]       rdst;
  } slot_t;

  localparam logic [3:0] TMO = 4'(TIMEOUT);

  slot_t [3:0] slots_q, slots_d;
  logic  [3:0] valid_q, valid_d;
  logic  [2:0] cnt_q,   cnt_d;
  logic  [3:0] timer_q, timer_d;

  logic        send;
  logic        ready;
  logic        accept;
  slot_t       in_slot;
  logic  [3:0] hit1, hit2;
  logic        in_hit1, in_hit2;

`ifdef DISPATCH_WAKE_SNOOP_EN
  logic [3:0]         bc_v;
  logic [4*PHY_W-1:0] bc_t;

  assign bc_v = {bus.DU_Commit, bus.BU_Commit, bus.ALU1_Commit, bus.ALU0_Commit};
  assign bc_t = {bus.DU_Phydst, bus.BU_Phydst, bus.ALU1_Phydst, bus.ALU0_Phydst};

  // A broadcast tag only counts when its own commit strobe is high.
  function automatic logic tag_hit(input logic [PHY_W-1:0] tag,
                                   input logic [3:0] v,
                                   input logic [4*PHY_W-1:0] t);
    logic h;
    h = 1'b0;
    for (int b = 0; b < 4; b++) h = h | (v[b] && (t[b*PHY_W +: PHY_W] == tag));
    return h;
  endfunction

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      hit1[k] = tag_hit(slots_q[k].src1, bc_v, bc_t);
      hit2[k] = tag_hit(slots_q[k].src2, bc_v, bc_t);
    end
    in_hit1 = tag_hit(bus.In_Src1, bc_v, bc_t);
    in_hit2 = tag_hit(bus.In_Src2, bc_v, bc_t);
  end
`else
  assign hit1    = 4'b0000;
  assign hit2    = 4'b0000;
  assign in_hit1 = 1'b0;
  assign in_hit2 = 1'b0;
`endif

  assign send   = ((cnt_q == 3'd4) || (cnt_q != 3'd0 && timer_q >= TMO))
                  && !bus.Issue_window_full && !bus.flush;
  assign ready  = !bus.flush && (cnt_q < 3'd4 || send);
  assign accept = bus.In_Valid && ready;

  always_comb begin
    in_slot.func      = bus.In_Function;
    in_slot.op        = bus.In_Operation;
    in_slot.imm       = bus.In_imm;
    in_slot.pc        = bus.In_PC;
    in_slot.phydst    = bus.In_Phydst;
    in_slot.src1      = bus.In_Src1;
    in_slot.src2      = bus.In_Src2;
    in_slot.src1_wake = bus.In_Src1_Wake | in_hit1;
    in_slot.src2_wake = bus.In_Src2_Wake | in_hit2;
    in_slot.rdst      = bus.In_Rdst;
  end

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    slots_d = slots_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    if (bus.flush) begin
      slots_d = '0;
      valid_d = 4'b0000;
      cnt_d   = 3'd0;
      timer_d = 4'd0;
    end else if (send) begin
      // The window captures this edge; a same-cycle accept opens the next bundle.
      slots_d = '0;
      valid_d = 4'b0000;
      cnt_d   = 3'd0;
      timer_d = 4'd0;
      if (accept) begin
        slots_d[0] = in_slot;
        valid_d[0] = 1'b1;
        cnt_d      = 3'd1;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        slots_d[k].src1_wake = slots_q[k].src1_wake | (valid_q[k] & hit1[k]);
        slots_d[k].src2_wake = slots_q[k].src2_wake | (valid_q[k] & hit2[k]);
      end
      if (cnt_q != 3'd0 && timer_q < TMO) timer_d = timer_q + 4'd1;
      if (accept) begin
        slots_d[cnt_q[1:0]] = in_slot;
        valid_d[cnt_q[1:0]] = 1'b1;
        cnt_d               = cnt_q + 3'd1;
      end
    end
  end

  // NOTE: slot storage is reset along with the control state so a reset leaves no stale fields on the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slots_q <= '0;
      valid_q <= 4'b0000;
      cnt_q   <= 3'd0;
      timer_q <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      slots_q <= slots_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    slot_t view;
    bus.In_Ready       = rst && ready;
    bus.Inst_Valid     = send ? valid_q : 4'b0000;
    bus.Bundle_Count   = bus.flush ? 3'd0 : cnt_q;
    bus.Inst_Function  = '0;
    bus.Inst_Operation = '0;
    bus.Inst_imm       = '0;
    bus.Inst_PC        = '0;
    bus.Inst_Phydst    = '0;
    bus.Inst_Src1      = '0;
    bus.Inst_Src2      = '0;
    bus.Inst_Src1_Wake = 4'b0000;
    bus.Inst_Src2_Wake = 4'b0000;
    bus.Inst_Rdst      = '0;
    for (int k = 0; k < 4; k++) begin
      view = bus.flush ? slot_t'('0) : slots_q[k];
      bus.Inst_Function[4*k +: 4]          = view.func;
      bus.Inst_Operation[5*k +: 5]         = view.op;
      bus.Inst_imm[32*k +: 32]             = view.imm;
      bus.Inst_PC[32*k +: 32]              = view.pc;
      bus.Inst_Phydst[PHY_W*k +: PHY_W]    = view.phydst;
      bus.Inst_Src1[PHY_W*k +: PHY_W]      = view.src1;
      bus.Inst_Src2[PHY_W*k +: PHY_W]      = view.src2;
      bus.Inst_Rdst[5*k +: 5]              = view.rdst;
      // Same-cycle broadcasts are forwarded so a wake on the send edge is not lost.
      bus.Inst_Src1_Wake[k] = view.src1_wake | (valid_q[k] & hit1[k] & !bus.flush);
      bus.Inst_Src2_Wake[k] = view.src2_wake | (valid_q[k] & hit2[k] & !bus.flush);
    end
  end

endmodule
